// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: valid/ready stream bundle for the pipelined barrel shifter.
// Producer side: in_valid, in_data, in_shift, in_mode, with in_ready coming back.
// Consumer side: out_valid, out_data, with out_ready coming back.
// The master modport drives the operands and out_ready; the slave modport is the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [SHW-1:0] in_shift;
  logic [1:0] in_mode;
  modport master (
    output in_valid, in_data, in_shift, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_shift, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: WIDTH-bit shifter, one mux layer per register stage, modes arith/logical right, left, rotate right.
// Ports: clk, rst_n (async active-low), bus (slave modport: in_valid/in_ready/in_data/in_shift/in_mode, out_valid/out_ready/out_data).
// Build option BARREL_ROUND_EN: mode 00 rounds toward zero using a per-stage sticky bit instead of flooring.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH),
  parameter int STAGES = SHW
) (
  input logic clk,
  input logic rst_n,
  pipelined_barrel_shifter_if.slave bus
);
  localparam logic [WIDTH-1:0] ONES = '1;
  logic [WIDTH-1:0] d_q [STAGES], nd [STAGES];
  logic [SHW-1:0] s_q [STAGES], ns [STAGES];
  logic [1:0] m_q [STAGES], nm [STAGES];
  logic [STAGES-1:0] g_q, ng, v_q, nv;
  logic [WIDTH-1:0] cd, sd, lr, ll, rr, ar;
  logic [SHW-1:0] cs;
  logic [1:0] cm;
  logic cg, cv, adv;
`ifdef BARREL_ROUND_EN
  logic [STAGES-1:0] k_q, nk;
  logic ck, sk;
`endif
  // Global stall: the whole pipe moves only when the output slot can drain.
  assign adv = bus.out_ready || !v_q[STAGES-1];
  assign bus.in_ready = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out_data = d_q[STAGES-1];
  // The c* variables walk the pipe: stage k computes from them, then they load stage k's registers for stage k+1.
  always_comb begin
    nd = d_q;
    ns = s_q;
    nm = m_q;
    ng = g_q;
    nv = v_q;
    cd = bus.in_data;
    cs = bus.in_shift;
    cm = bus.in_mode;
    cg = bus.in_data[WIDTH-1];
    cv = bus.in_valid;
    sd = '0;
    lr = '0;
    ll = '0;
    rr = '0;
    ar = '0;
`ifdef BARREL_ROUND_EN
    nk = k_q;
    ck = 1'b0;
    sk = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      lr = cd >> (1 << k);
      ll = cd << (1 << k);
      rr = lr | (cd << (WIDTH - (1 << k)));
      ar = lr | ({WIDTH{cg}} & ~(ONES >> (1 << k)));
      sd = !cs[k] ? cd : cm == 2'd0 ? ar : cm == 2'd1 ? lr : cm == 2'd2 ? ll : rr;
`ifdef BARREL_ROUND_EN
      // Sticky collects every bit dropped off the bottom; a negative inexact quotient is bumped toward zero.
      sk = ck | (cs[k] & |(cd & ~(ONES << (1 << k))));
      if (k == STAGES - 1 && cm == 2'd0 && cg && sk) sd = sd + 1'b1;
      nk[k] = sk;
      ck = k_q[k];
`endif
      nd[k] = sd;
      ns[k] = cs;
      nm[k] = cm;
      ng[k] = cg;
      nv[k] = cv;
      cd = d_q[k];
      cs = s_q[k];
      cm = m_q[k];
      cg = g_q[k];
      cv = v_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_q <= '{default: '0};
      s_q <= '{default: '0};
      m_q <= '{default: '0};
      g_q <= '0;
      v_q <= '0;
`ifdef BARREL_ROUND_EN
      k_q <= '0;
`endif
    end else if (adv) begin
      d_q <= nd;
      s_q <= ns;
      m_q <= nm;
      g_q <= ng;
      v_q <= nv;
`ifdef BARREL_ROUND_EN
      k_q <= nk;
`endif
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: table vectors plus scoreboard-checked streams, stalls, reset and a full mode-00 sweep.
module tb_pipelined_barrel_shifter;
  localparam int STAGES = 3;
  typedef struct {
    logic [7:0] d;
    logic [2:0] n;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;
  typedef struct {
    logic [7:0] d;
    int c;
    bit lat;
  } sb_t;
`ifdef BARREL_ROUND_EN
  localparam logic [7:0] R9C = 8'hF4;
`else
  localparam logic [7:0] R9C = 8'hF3;
`endif
  logic clk = 1'b0;
  logic rst_n;
  pipelined_barrel_shifter_if #(.WIDTH(8)) bif ();
  pipelined_barrel_shifter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0, cyc = 0, n_out = 0;
  bit chk_lat = 0, prev_stall = 0;
  logic [7:0] prev_data;
  sb_t sb[$];
  vec_t tbl[15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] model(input logic [7:0] d, input int n, input logic [1:0] m);
    int x;
    logic [15:0] dd;
    x = $signed(d);
    dd = {d, d} >> n;
    case (m)
`ifdef BARREL_ROUND_EN
      2'd0: model = 8'(x / (1 << n));
`else
      2'd0: model = 8'(x >>> n);
`endif
      2'd1: model = d >> n;
      2'd2: model = d << n;
      default: model = dd[7:0];
    endcase
  endfunction
  task automatic tick(input logic [7:0] exp, output bit acc);
    sb_t e;
    @(negedge clk);
    acc = bif.in_valid && bif.in_ready;
    if (prev_stall) chk("hold_data", bif.out_data, prev_data);
    if (bif.out_valid && !bif.out_ready) chk("stall_in_ready", bif.in_ready, 0);
    if (bif.out_valid && bif.out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_out: got %0h, expected no output", bif.out_data);
      end else begin
        e = sb.pop_front();
        chk("result", bif.out_data, e.d);
        if (e.lat) chk("latency", cyc - e.c, STAGES);
      end
    end
    if (acc) sb.push_back('{d: exp, c: cyc, lat: chk_lat});
    prev_stall = bif.out_valid && !bif.out_ready;
    prev_data = bif.out_data;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] d, input int n, input logic [1:0] m);
    bif.in_valid = 1'b1;
    bif.in_data = d;
    bif.in_shift = 3'(n);
    bif.in_mode = m;
  endtask
  task automatic drain();
    bit acc;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() > 0; k++) tick(8'h0, acc);
    chk("drain_empty", sb.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit acc;
    int i, t, n0;
    logic [7:0] w;
    logic [2:0] sh;
    logic [1:0] md;
    tbl[0]  = '{8'h9C, 3'd3, 2'd0, R9C};
    tbl[1]  = '{8'h64, 3'd3, 2'd0, 8'h0C};
    tbl[2]  = '{8'h9C, 3'd3, 2'd1, 8'h13};
    tbl[3]  = '{8'h9C, 3'd3, 2'd2, 8'hE0};
    tbl[4]  = '{8'h9C, 3'd3, 2'd3, 8'h93};
    tbl[5]  = '{8'hA5, 3'd0, 2'd0, 8'hA5};
    tbl[6]  = '{8'hA5, 3'd0, 2'd1, 8'hA5};
    tbl[7]  = '{8'hA5, 3'd0, 2'd2, 8'hA5};
    tbl[8]  = '{8'hA5, 3'd0, 2'd3, 8'hA5};
    tbl[9]  = '{8'h80, 3'd7, 2'd0, 8'hFF};
    tbl[10] = '{8'h80, 3'd7, 2'd1, 8'h01};
    tbl[11] = '{8'h01, 3'd7, 2'd2, 8'h80};
    tbl[12] = '{8'h01, 3'd7, 2'd3, 8'h02};
    tbl[13] = '{8'h81, 3'd1, 2'd3, 8'hC0};
    tbl[14] = '{8'h7F, 3'd7, 2'd0, 8'h00};
    rst_n = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data = '0;
    bif.in_shift = '0;
    bif.in_mode = '0;
    bif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", bif.out_valid, 0);
    chk("reset_out_data", bif.out_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", bif.in_ready, 1);
    // Table vectors, back-to-back, unstalled, latency checked.
    chk_lat = 1;
    bif.out_ready = 1'b1;
    foreach (tbl[j]) begin
      drive(tbl[j].d, tbl[j].n, tbl[j].m);
      tick(tbl[j].e, acc);
      chk("table_accept", acc, 1);
    end
    drain();
    chk_lat = 0;
    // Eight random words with a 4-cycle consumer stall mid-stream.
    n0 = n_out;
    i = 0;
    t = 0;
    w = 8'($urandom);
    sh = 3'($urandom);
    md = 2'($urandom);
    while (i < 8 && t < 100) begin
      drive(w, sh, md);
      bif.out_ready = !(t >= 3 && t < 7);
      tick(model(w, sh, md), acc);
      if (acc) begin
        i++;
        w = 8'($urandom);
        sh = 3'($urandom);
        md = 2'($urandom);
      end
      t++;
    end
    chk("stream_accepted", i, 8);
    drain();
    chk("stream_count", n_out - n0, 8);
    // Fill the pipe, then pulse reset inside one clock phase.
    bif.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(8'(8'h31 * k), k, 2'(k));
      tick(model(8'(8'h31 * k), k, 2'(k)), acc);
    end
    bif.in_valid = 1'b0;
    tick(8'h0, acc);
    chk("pre_reset_valid", bif.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", bif.out_valid, 0);
    chk("async_reset_data", bif.out_data, 0);
    #2;
    rst_n = 1'b1;
    sb.delete();
    prev_stall = 0;
    #1;
    chk("post_reset_in_ready", bif.in_ready, 1);
    bif.out_ready = 1'b1;
    n0 = n_out;
    repeat (6) tick(8'h0, acc);
    chk("no_spurious_after_reset", n_out - n0, 0);
    drive(8'hC3, 2, 2'd0);
    tick(model(8'hC3, 2, 2'd0), acc);
    chk("post_reset_accept", acc, 1);
    drain();
    // Mode 00 sweep over every operand and shift, with random backpressure.
    i = 0;
    t = 0;
    while (i < 2048 && t < 10000) begin
      drive(8'(i >> 3), i & 7, 2'd0);
      bif.out_ready = $urandom_range(0, 3) != 0;
      tick(model(8'(i >> 3), i & 7, 2'd0), acc);
      if (acc) i++;
      t++;
    end
    chk("sweep_accepted", i, 2048);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
